instr_fetch_decode: RTL and testbench

Front-end stage of the micro CPU: fetches 16-bit instruction words from synchronous program memory, decodes the 8-bit opcode field into an `Operation`, an op type and modifier flags, and presents one decoded instruction at a time to the execute stage over a valid/ready handshake. It owns the program counter and accepts jump redirects from execute. An unrecognised opcode halts the stage.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/cpu_opcode_decoder.sv | 56 +++++
 rtl/instr_fetch_decode.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_decode.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and field bounds for the micro CPU front end.
//   Operation     : decoded operation, 4 bits, LOAD is the reset value.
//   DecodedInstr  : result of decoding one 8-bit opcode.
//   Field bounds  : where the opcode and operand live in a program word.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PM_DATA_WIDTH = 16;

    localparam int OPCODE_MSB  = 15;
    localparam int OPCODE_LSB  = 8;
    localparam int OPERAND_MSB = 7;
    localparam int OPERAND_LSB = 0;

    // Opcode[7:6] classes
    localparam logic [1:0] OPTYPE_MEM   = 2'd0;
    localparam logic [1:0] OPTYPE_ARITH = 2'd1;
    localparam logic [1:0] OPTYPE_LOGIC = 2'd2;
    localparam logic [1:0] OPTYPE_JUMP  = 2'd3;

    typedef enum logic [3:0] {
        Operation_LOAD  = 4'd0,
        Operation_STORE = 4'd1,
        Operation_ADD   = 4'd2,
        Operation_SUB   = 4'd3,
        Operation_NOR   = 4'd4,
        Operation_NAND  = 4'd5,
        Operation_XOR   = 4'd6,
        Operation_XNOR  = 4'd7,
        Operation_JUMP  = 4'd8,
        Operation_JZ    = 4'd9,
        Operation_JC    = 4'd10,
        Operation_JN    = 4'd11
    } Operation;

    typedef struct packed {
        Operation   op;
        logic [1:0] op_type;
        logic       imm;
        logic       carry;
        logic       illegal;
    } DecodedInstr;

endpackage

// File: rtl/cpu_opcode_decoder.sv
// ---------------------------------------------------------------------------
// cpu_opcode_decoder
// Purely combinational decode of one 8-bit opcode.
//   i_opcode  : opcode field of the program word
//   o_decoded : operation, op type, immediate/carry flags, illegal flag
// Any set bit in a field that must be zero for its class marks the opcode
// illegal; the other decoded fields are then don't-care.
// ---------------------------------------------------------------------------
module cpu_opcode_decoder
    import cpu_pkg::*;
(
    input  logic [7:0]  i_opcode,
    output DecodedInstr o_decoded
);

    // Decode by class in opcode[7:6]; every field gets a default so the
    // block stays latch-free.
    always_comb begin
        o_decoded         = '0;
        o_decoded.op      = Operation_LOAD;
        o_decoded.op_type = i_opcode[7:6];
        case (i_opcode[7:6])
            OPTYPE_MEM: begin
                o_decoded.op      = i_opcode[0] ? Operation_STORE : Operation_LOAD;
                o_decoded.imm     = i_opcode[1];
                o_decoded.illegal = |i_opcode[5:2];
            end
            OPTYPE_ARITH: begin
                o_decoded.op      = i_opcode[0] ? Operation_SUB : Operation_ADD;
                o_decoded.carry   = i_opcode[1];
                o_decoded.imm     = i_opcode[2];
                o_decoded.illegal = |i_opcode[5:3];
            end
            OPTYPE_LOGIC: begin
                case (i_opcode[1:0])
                    2'd0:    o_decoded.op = Operation_NOR;
                    2'd1:    o_decoded.op = Operation_NAND;
                    2'd2:    o_decoded.op = Operation_XOR;
                    default: o_decoded.op = Operation_XNOR;
                endcase
                o_decoded.imm     = i_opcode[2];
                o_decoded.illegal = |i_opcode[5:3];
            end
            default: begin
                case (i_opcode[1:0])
                    2'd0:    o_decoded.op = Operation_JUMP;
                    2'd1:    o_decoded.op = Operation_JZ;
                    2'd2:    o_decoded.op = Operation_JC;
                    default: o_decoded.op = Operation_JN;
                endcase
                o_decoded.illegal = |i_opcode[5:2];
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
// Front end of the micro CPU: fetches program words, decodes them and hands
// one decoded instruction at a time to execute over valid/ready. Owns the PC
// and takes jump redirects from execute. An illegal opcode halts the stage
// until reset.
//   clk, reset_n        : clock, asynchronous active-low reset
//   pm_rd_en, pm_addr   : program-memory read request (data next cycle)
//   pm_rdata            : program word, [15:8] opcode, [7:0] operand
//   redirect_valid/_pc  : one-cycle jump-taken pulse and its target
//   dec_valid/dec_ready : handshake to execute
//   dec_op .. dec_pc    : decoded instruction, held stable while presented
//   illegal             : high while halted on an illegal opcode
// ---------------------------------------------------------------------------
module instr_fetch_decode
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
)
(
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     pm_rd_en,
    output logic [PC_WIDTH-1:0]      pm_addr,
    input  logic [PM_DATA_WIDTH-1:0] pm_rdata,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [3:0]               dec_op,
    output logic [1:0]               dec_op_type,
    output logic                     dec_imm,
    output logic                     dec_carry,
    output logic [7:0]               dec_operand,
    output logic [PC_WIDTH-1:0]      dec_pc,
    output logic                     illegal
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} FsmState;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    FsmState             r_state;
    FsmState             w_nextState;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pcNext;
    logic                r_decValid;
    logic                w_validNext;
    logic                w_load;
    DecodedInstr         w_decoded;

    Operation            r_decOp;
    logic [1:0]          r_decOpType;
    logic                r_decImm;
    logic                r_decCarry;
    logic [7:0]          r_decOperand;
    logic [PC_WIDTH-1:0] r_decPc;

    cpu_opcode_decoder u_decoder (
        .i_opcode  (pm_rdata[OPCODE_MSB:OPCODE_LSB]),
        .o_decoded (w_decoded)
    );

    // Next-state, PC and read-strobe logic. A redirect overrides everything
    // outside HALT; in HOLD it still lets a coincident accept complete but
    // suppresses the follow-on read, since that address is now stale.
    always_comb begin
        w_nextState = r_state;
        w_pcNext    = r_pc;
        w_validNext = r_decValid;
        w_load      = 1'b0;
        pm_rd_en    = 1'b0;
        case (r_state)
            FETCH: begin
                pm_rd_en = 1'b1;
                if (redirect_valid) begin
                    w_pcNext = redirect_pc;
                end else begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_pcNext    = redirect_pc;
                    w_nextState = FETCH;
                end else if (w_decoded.illegal) begin
                    w_nextState = HALT;
                end else begin
                    w_load      = 1'b1;
                    w_validNext = 1'b1;
                    w_pcNext    = r_pc + PC_ONE;
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    w_pcNext    = redirect_pc;
                    w_validNext = 1'b0;
                    w_nextState = FETCH;
                end else if (dec_ready) begin
                    w_validNext = 1'b0;
                    pm_rd_en    = 1'b1;
                    w_nextState = WAIT;
                end
            end
            default: begin
                w_nextState = HALT;
            end
        endcase
    end

    // State, PC and valid flag; reset drops any read in flight by simply
    // returning to FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_decValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_pc       <= w_pcNext;
            r_decValid <= w_validNext;
        end
    end

    // Decoded-instruction register: only loaded when a legal word is
    // accepted out of WAIT, so the outputs move only as dec_valid rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_decOp      <= Operation_LOAD;
            r_decOpType  <= '0;
            r_decImm     <= 1'b0;
            r_decCarry   <= 1'b0;
            r_decOperand <= '0;
            r_decPc      <= '0;
        end else if (w_load) begin
            r_decOp      <= w_decoded.op;
            r_decOpType  <= w_decoded.op_type;
            r_decImm     <= w_decoded.imm;
            r_decCarry   <= w_decoded.carry;
            r_decOperand <= pm_rdata[OPERAND_MSB:OPERAND_LSB];
            r_decPc      <= r_pc;
        end
    end

    assign pm_addr     = r_pc;
    assign dec_valid   = r_decValid;
    assign dec_op      = r_decOp;
    assign dec_op_type = r_decOpType;
    assign dec_imm     = r_decImm;
    assign dec_carry   = r_decCarry;
    assign dec_operand = r_decOperand;
    assign dec_pc      = r_decPc;
    assign illegal     = (r_state == HALT);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_decode
// Bench for instr_fetch_decode: a synchronous program memory, a
// transaction-level model of the fetch/decode stage, directed scenarios with
// literal expectations and a randomized run.
// ---------------------------------------------------------------------------
module tb_instr_fetch_decode;
    import cpu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        pm_rd_en;
    logic [7:0]  pm_addr;
    logic [15:0] pm_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_op;
    logic [1:0]  dec_op_type;
    logic        dec_imm;
    logic        dec_carry;
    logic [7:0]  dec_operand;
    logic [7:0]  dec_pc;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];

    Operation memTab   [2] = '{Operation_LOAD, Operation_STORE};
    Operation arithTab [2] = '{Operation_ADD, Operation_SUB};
    Operation logicTab [4] = '{Operation_NOR, Operation_NAND, Operation_XOR, Operation_XNOR};
    Operation jumpTab  [4] = '{Operation_JUMP, Operation_JZ, Operation_JC, Operation_JN};

    // Model of the stage: what it is currently doing, expressed as
    // "a fetch is owed", "a word is in flight", "an instruction is offered".
    bit        mHalted;
    bit        mNeedFetch;
    bit        mInflight;
    bit        mValid;
    logic [7:0] mPc;
    logic [7:0] mInflightAddr;
    Operation  mOp;
    logic [1:0] mType;
    bit        mImm;
    bit        mCarry;
    logic [7:0] mOperand;
    logic [7:0] mDecPc;

    instr_fetch_decode #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pm_rd_en       (pm_rd_en),
        .pm_addr        (pm_addr),
        .pm_rdata       (pm_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_op         (dec_op),
        .dec_op_type    (dec_op_type),
        .dec_imm        (dec_imm),
        .dec_carry      (dec_carry),
        .dec_operand    (dec_operand),
        .dec_pc         (dec_pc),
        .illegal        (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous program memory: data appears the cycle after the strobe.
    initial pm_rdata = '0;
    always @(posedge clk) begin
        if (pm_rd_en) pm_rdata <= mem[pm_addr];
    end

    function automatic void checkVal(input string name, input logic [31:0] actual,
                                     input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Opcode rules: class from [7:6], reserved bits must be zero.
    function automatic void refDecode(input logic [7:0] opc, output bit legal,
                                      output Operation op, output bit imm, output bit carry);
        logic [7:0] reservedMask;
        int t;
        t = int'(opc[7:6]);
        reservedMask = (t == 1 || t == 2) ? 8'h38 : 8'h3C;
        legal = ((opc & reservedMask) == 8'h00);
        imm   = 1'b0;
        carry = 1'b0;
        case (t)
            0: begin op = memTab[opc[0]];      imm = opc[1]; end
            1: begin op = arithTab[opc[0]];    carry = opc[1]; imm = opc[2]; end
            2: begin op = logicTab[opc[1:0]];  imm = opc[2]; end
            default: op = jumpTab[opc[1:0]];
        endcase
    endfunction

    function automatic logic [15:0] randWord();
        logic [7:0] opc;
        logic [1:0] t;
        if ($urandom_range(0, 9) == 0) begin
            opc = 8'($urandom);
        end else begin
            t   = 2'($urandom);
            opc = {t, 6'b0} | 8'($urandom_range(0, (t == 2'd1 || t == 2'd2) ? 7 : 3));
        end
        return {opc, 8'($urandom)};
    endfunction

    function automatic void modelReset();
        mHalted    = 1'b0;
        mNeedFetch = 1'b1;
        mInflight  = 1'b0;
        mValid     = 1'b0;
        mPc        = 8'h00;
        mOp        = Operation_LOAD;
        mType      = 2'd0;
        mImm       = 1'b0;
        mCarry     = 1'b0;
        mOperand   = 8'h00;
        mDecPc     = 8'h00;
    endfunction

    // Advance the model across one rising edge given that cycle's inputs.
    function automatic void modelAdvance(input bit rdy, input bit rv, input logic [7:0] rpc);
        bit legal, imm, carry;
        Operation op;
        logic [15:0] word;
        if (mHalted) return;
        if (rv) begin
            mPc        = rpc;
            mValid     = 1'b0;
            mInflight  = 1'b0;
            mNeedFetch = 1'b1;
        end else if (mNeedFetch) begin
            mNeedFetch    = 1'b0;
            mInflight     = 1'b1;
            mInflightAddr = mPc;
        end else if (mInflight) begin
            word = mem[mInflightAddr];
            refDecode(word[15:8], legal, op, imm, carry);
            mInflight = 1'b0;
            if (!legal) begin
                mHalted = 1'b1;
            end else begin
                mOp      = op;
                mType    = word[15:14];
                mImm     = imm;
                mCarry   = carry;
                mOperand = word[7:0];
                mDecPc   = mInflightAddr;
                mValid   = 1'b1;
                mPc      = mPc + 8'd1;
            end
        end else if (mValid && rdy) begin
            mValid        = 1'b0;
            mInflight     = 1'b1;
            mInflightAddr = mPc;
        end
    endfunction

    task automatic checkOutput();
        checkVal("dec_valid",   dec_valid,   mValid);
        checkVal("illegal",     illegal,     mHalted);
        checkVal("dec_op",      dec_op,      mOp);
        checkVal("dec_op_type", dec_op_type, mType);
        checkVal("dec_imm",     dec_imm,     mImm);
        checkVal("dec_carry",   dec_carry,   mCarry);
        checkVal("dec_operand", dec_operand, mOperand);
        checkVal("dec_pc",      dec_pc,      mDecPc);
    endtask

    // One clock cycle: drive inputs at the falling edge, check the read
    // request, let the edge happen, then check registered outputs.
    task automatic applyStimulus(input bit rdy, input bit rv, input logic [7:0] rpc);
        bit expRd;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        expRd = 1'b0;
        if (!mHalted) begin
            if (mNeedFetch)  expRd = 1'b1;
            else if (mValid) expRd = rdy && !rv;
        end
        checkVal("pm_rd_en", pm_rd_en, expRd);
        if (expRd) checkVal("pm_addr", pm_addr, mPc);
        @(posedge clk);
        modelAdvance(rdy, rv, rpc);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        reset_n        = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        #2;
        modelReset();
        checkVal("reset dec_valid", dec_valid, 0);
        checkVal("reset dec_op",    dec_op,    Operation_LOAD);
        checkVal("reset illegal",   illegal,   0);
        checkVal("reset dec_pc",    dec_pc,    0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n        = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h4412;
        mem[8'h01] = 16'h83C5;
        mem[8'h02] = 16'h0001;
        mem[8'h20] = 16'hFF00;
        mem[8'h40] = 16'h4733;
        mem[8'h60] = 16'hC100;
        mem[8'hFF] = 16'h8611;
        modelReset();

        // Reset and first fetch
        doReset();
        checkVal("first pm_rd_en", pm_rd_en, 1);
        checkVal("first pm_addr",  pm_addr,  0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("first dec_valid",   dec_valid,   1);
        checkVal("first dec_op",      dec_op,      Operation_ADD);
        checkVal("first dec_op_type", dec_op_type, 1);
        checkVal("first dec_imm",     dec_imm,     1);
        checkVal("first dec_carry",   dec_carry,   0);
        checkVal("first dec_operand", dec_operand, 8'h12);
        checkVal("first dec_pc",      dec_pc,      0);

        // Backpressure on XNOR
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("bp dec_op", dec_op, Operation_XNOR);
        checkVal("bp dec_pc", dec_pc, 1);
        repeat (5) begin
            applyStimulus(0, 0, 0);
            checkVal("bp no read",   pm_rd_en,    0);
            checkVal("bp stable op", dec_op,      Operation_XNOR);
            checkVal("bp operand",   dec_operand, 8'hC5);
            checkVal("bp valid",     dec_valid,   1);
        end
        dec_ready = 1'b1;
        #1;
        checkVal("bp accept read", pm_rd_en, 1);
        checkVal("bp accept addr", pm_addr,  2);
        applyStimulus(1, 0, 0);

        // Redirect while an illegal word sits in WAIT
        applyStimulus(0, 1, 8'h20);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 8'h40);
        checkVal("rw no halt",   illegal,   0);
        checkVal("rw not valid", dec_valid, 0);
        checkVal("rw rd_en",     pm_rd_en,  1);
        checkVal("rw addr",      pm_addr,   8'h40);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("rw dec_pc",    dec_pc,    8'h40);
        checkVal("rw dec_op",    dec_op,    Operation_SUB);
        checkVal("rw dec_carry", dec_carry, 1);

        // Redirect and accept in the same HOLD cycle
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        #1;
        checkVal("coinc no read", pm_rd_en, 0);
        applyStimulus(1, 1, 8'h60);
        checkVal("coinc valid low", dec_valid, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("coinc dec_pc", dec_pc, 8'h60);
        checkVal("coinc dec_op", dec_op, Operation_JZ);

        // PC wrap
        applyStimulus(0, 1, 8'hFF);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("wrap dec_pc", dec_pc, 8'hFF);
        checkVal("wrap dec_op", dec_op, Operation_XOR);
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        #1;
        checkVal("wrap rd_en", pm_rd_en, 1);
        checkVal("wrap addr",  pm_addr,  8'h00);
        applyStimulus(1, 0, 0);

        // Illegal opcode halts, redirects ignored
        mem[8'h01] = 16'h0400;
        applyStimulus(0, 0, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkVal("halt illegal", illegal,   1);
        checkVal("halt valid",   dec_valid, 0);
        applyStimulus(1, 1, 8'h10);
        checkVal("halt no read", pm_rd_en, 0);
        checkVal("halt stays",   illegal,  1);

        // Opcode sweep, one opcode per address
        doReset();
        for (int k = 0; k < 256; k++) begin
            mem[k] = {8'(k), 8'($urandom)};
            applyStimulus(1, 1, 8'(k));
            applyStimulus(0, 0, 0);
            applyStimulus(0, 0, 0);
            if (mHalted) doReset();
        end

        // Randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = randWord();
        doReset();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 8, 8'($urandom));
            if (mHalted && $urandom_range(0, 7) == 0) doReset();
            else if ($urandom_range(0, 499) == 0) doReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
